// File: rtl/sub_table_pkg.sv
// Shared definitions for the 6x6 substitution-table encryptor/decryptor pair:
// key storage type, table row/column key positions and character helpers.
package sub_table_pkg;

    localparam int unsigned KEY_LEN = 12;

    typedef logic [0:KEY_LEN-1][7:0] key_t;

    // Key byte positions that supply each table row / column character.
    localparam logic [3:0] ROW_SEL [0:5] = '{4'd0, 4'd11, 4'd9, 4'd3, 4'd5, 4'd6};
    localparam logic [3:0] COL_SEL [0:5] = '{4'd10, 4'd8, 4'd1, 4'd2, 4'd4, 4'd7};

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        VALID,
        INVALID
    } chk_state_t;

    typedef struct packed {
        logic        upper;
        logic [15:0] pair;
    } ctxt_entry_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    function automatic logic is_alnum(input logic [7:0] c);
        return ((c >= 8'h61) && (c <= 8'h7A)) ||
               ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h30) && (c <= 8'h39));
    endfunction

    function automatic logic [5:0] char_idx(input logic [7:0] c);
        logic [7:0] d;
        d = 8'd0;
        if ((c >= 8'h61) && (c <= 8'h7A)) begin
            d = c - 8'h61;
        end else if ((c >= 8'h41) && (c <= 8'h5A)) begin
            d = c - 8'h41;
        end else if ((c >= 8'h30) && (c <= 8'h39)) begin
            d = c - 8'h30 + 8'd26;
        end
        return d[5:0];
    endfunction

endpackage

// File: rtl/sub_key_checker.sv
// Sequential key legality checker: scans one key index per cycle for charset
// membership and uniqueness against all earlier bytes.
module sub_key_checker
    import sub_table_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  key_t key,
    input  logic restart,
    output logic key_valid,
    output logic error_flag_key
);

    chk_state_t state, state_n;
    logic [3:0] idx, idx_n;
    logic       bad, bad_n;
    logic       dup;
    logic       fail;

    always_comb begin
        dup = 1'b0;
        for (int unsigned j = 0; j < KEY_LEN; j++) begin
            if ((4'(j) < idx) && (key[4'(j)] == key[idx])) begin
                dup = 1'b1;
            end
        end
        fail = dup || !is_alnum(key[idx]);
    end

    // Failures are accumulated and the verdict is taken at the last index,
    // so VALID and INVALID both appear exactly KEY_LEN cycles after a write.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        bad_n   = bad;
        if (restart) begin
            state_n = CHECK;
            idx_n   = '0;
            bad_n   = 1'b0;
        end else if (state == CHECK) begin
            if (idx == 4'(KEY_LEN - 1)) begin
                state_n = (bad || fail) ? INVALID : VALID;
            end else begin
                idx_n = idx + 1'b1;
                bad_n = bad || fail;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CHECK;
            idx   <= '0;
            bad   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            bad   <= bad_n;
        end
    end

    assign key_valid      = (state == VALID);
    assign error_flag_key = (state == INVALID);

endmodule

// File: rtl/ciphertext_encryptor.sv
// Substitution-table encryptor: key store + checker, plaintext handshake,
// 6x6 table lookup and a small output FIFO with valid/ready backpressure.
module ciphertext_encryptor
    import sub_table_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  key_byte,
    input  logic [3:0]  byte_pos,
    input  logic        key_byte_val,
    input  logic [7:0]  plaintext,
    input  logic        ptxt_valid,
    output logic        ptxt_ready,
    output logic [15:0] ciphertext,
    output logic        upper_lower,
    output logic        ctxt_valid,
    input  logic        ctxt_ready,
    output logic        key_valid,
    output logic        error_flag_key,
    output logic        error_flag_ptxt
);

    localparam int unsigned PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    key_t        key;
    logic        key_wr;
    ctxt_entry_t fifo_mem [OUT_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic        full;
    logic        accept;
    logic        push;
    logic        pop;
    logic [5:0]  idx;
    logic [2:0]  row;
    logic [2:0]  col;
    ctxt_entry_t new_entry;

    assign key_wr = key_byte_val && (byte_pos < 4'(KEY_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            key <= {KEY_LEN{8'h30}};
        end else if (key_wr) begin
            key[byte_pos] <= key_byte;
        end
    end

    sub_key_checker u_checker (
        .clk            (clk),
        .rst            (rst),
        .key            (key),
        .restart        (key_wr),
        .key_valid      (key_valid),
        .error_flag_key (error_flag_key)
    );

    always_comb begin
        idx             = char_idx(plaintext);
        row             = 3'(idx / 6'd6);
        col             = 3'(idx % 6'd6);
        new_entry.upper = is_upper(plaintext);
        new_entry.pair  = {key[ROW_SEL[row]], key[COL_SEL[col]]};
    end

    assign full       = (count == (PW + 1)'(OUT_DEPTH));
    assign ptxt_ready = key_valid && !full && !key_byte_val;
    assign accept     = ptxt_valid && ptxt_ready;
    assign push       = accept && is_alnum(plaintext);
    assign ctxt_valid = (count != '0);
    assign pop        = ctxt_valid && ctxt_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            error_flag_ptxt <= 1'b0;
        end else begin
            error_flag_ptxt <= accept && !is_alnum(plaintext);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign ciphertext  = ctxt_valid ? fifo_mem[rd_ptr].pair  : '0;
    assign upper_lower = ctxt_valid ? fifo_mem[rd_ptr].upper : 1'b0;

endmodule
